// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: writer/reader FSM encoding, screen geometry and
// RGB565 field positions.
package fb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_COLLECT      = 3'd1,
        ST_WRITE_REQ    = 3'd2,
        ST_WAIT_RELEASE = 3'd3,
        ST_DONE         = 3'd4
    } state_t;

    localparam logic [13:0] FB_MAX_WIDTH  = 14'd800;
    localparam logic [13:0] FB_MAX_HEIGHT = 14'd480;
    localparam logic [13:0] WORDS_PER_ROW = FB_MAX_WIDTH / 14'd2;

    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

    localparam logic [3:0] MASK_HI_HALF = 4'b1100;
    localparam logic [3:0] MASK_LO_HALF = 4'b0011;

endpackage

// File: rtl/fb_word_packer.sv
// Places one RGB565 pixel into its half of a 32-bit SDRAM word and computes the
// word address of the pixel; even columns occupy [31:16], odd columns [15:0].
module fb_word_packer
    import fb_pkg::*;
#(
    parameter logic [13:0] MAX_WIDTH  = FB_MAX_WIDTH,
    parameter logic [13:0] MAX_HEIGHT = FB_MAX_HEIGHT,
    parameter logic [13:0] ROW_WORDS  = WORDS_PER_ROW,
    parameter logic [31:0] BASE_ADDR  = 32'd0
) (
    input  logic [13:0] cx,
    input  logic [13:0] cy,
    input  logic [15:0] pix_data,
    input  logic [31:0] word_in,
    input  logic [3:0]  mask_in,
    output logic        in_bounds,
    output logic [31:0] word_out,
    output logic [3:0]  mask_out,
    output logic [31:0] addr
);

    logic [15:0] pix_s;

    // Merge the pixel into the pending word and derive bounds and address.
    always_comb begin
        pix_s     = {pix_data[RGB_R_MSB:RGB_R_LSB],
                     pix_data[RGB_G_MSB:RGB_G_LSB],
                     pix_data[RGB_B_MSB:RGB_B_LSB]};
        in_bounds = (cx < MAX_WIDTH) && (cy < MAX_HEIGHT);
        if (cx[0]) begin
            word_out = {word_in[31:16], pix_s};
            mask_out = mask_in | MASK_LO_HALF;
        end else begin
            word_out = {pix_s, word_in[15:0]};
            mask_out = mask_in | MASK_HI_HALF;
        end
        addr = BASE_ADDR + ({18'd0, cy} * {18'd0, ROW_WORDS}) + {19'd0, cx[13:1]};
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Window pixel writer: walks a rectangular window, packs RGB565 pixel pairs into
// masked 32-bit SDRAM writes and flags the reader via screen_change.
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter logic [13:0] MAX_WIDTH  = FB_MAX_WIDTH,
    parameter logic [13:0] MAX_HEIGHT = FB_MAX_HEIGHT,
    parameter logic [31:0] BASE_ADDR  = 32'd0
) (
    input  logic        sdram_clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [13:0] win_x0,
    input  logic [13:0] win_y0,
    input  logic [13:0] win_w,
    input  logic [13:0] win_h,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wmask,
    input  logic        ram_ack,
    output logic        busy,
    output logic        done,
    output logic        screen_change
);

    state_t      state_r, state_s;
    logic [13:0] x0_r, y0_r, w_r, h_r;
    logic [13:0] cx_r, cy_r;
    logic [31:0] word_r, addr_r;
    logic [3:0]  mask_r;
    logic        last_r;
    logic        pix_ready_r, ram_wen_r, busy_r, done_r, screen_change_r;
    logic        pix_ready_s, ram_wen_s, busy_s, done_s, screen_change_s;

    logic        accept_s, last_col_s, last_row_s, last_pix_s, complete_s;
    logic        in_bounds_s;
    logic [31:0] word_s, addr_s;
    logic [3:0]  mask_s;

    fb_word_packer #(
        .MAX_WIDTH  (MAX_WIDTH),
        .MAX_HEIGHT (MAX_HEIGHT),
        .ROW_WORDS  (MAX_WIDTH >> 1),
        .BASE_ADDR  (BASE_ADDR)
    ) u_packer (
        .cx        (cx_r),
        .cy        (cy_r),
        .pix_data  (pix_data),
        .word_in   (word_r),
        .mask_in   (mask_r),
        .in_bounds (in_bounds_s),
        .word_out  (word_s),
        .mask_out  (mask_s),
        .addr      (addr_s)
    );

    // Window-end and word-completion decode; end comparisons use 15 bits so x0+w cannot wrap.
    always_comb begin
        accept_s   = pix_valid && pix_ready_r && (state_r == ST_COLLECT);
        last_col_s = (({1'b0, cx_r} + 15'd1) == ({1'b0, x0_r} + {1'b0, w_r}));
        last_row_s = (({1'b0, cy_r} + 15'd1) == ({1'b0, y0_r} + {1'b0, h_r}));
        last_pix_s = last_col_s && last_row_s;
        if (in_bounds_s) begin
            complete_s = cx_r[0] || last_col_s || last_pix_s;
        end else begin
            complete_s = (mask_r != 4'd0);
        end
    end

    // FSM state register.
    always_ff @(posedge sdram_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if ((win_w == 14'd0) || (win_h == 14'd0)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_COLLECT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (accept_s && complete_s) begin
                    state_s = ST_WRITE_REQ;
                end else if (accept_s && last_pix_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_COLLECT;
                end
            end
            ST_WRITE_REQ: begin
                if (ram_ack) begin
                    state_s = ST_WAIT_RELEASE;
                end else begin
                    state_s = ST_WRITE_REQ;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!ram_ack) begin
                    state_s = last_r ? ST_DONE : ST_COLLECT;
                end else begin
                    state_s = ST_WAIT_RELEASE;
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // FSM output decode, evaluated on the next state so the outputs can be registered.
    always_comb begin
        pix_ready_s     = (state_s == ST_COLLECT);
        ram_wen_s       = (state_s == ST_WRITE_REQ);
        busy_s          = (state_s == ST_COLLECT) || (state_s == ST_WRITE_REQ) ||
                          (state_s == ST_WAIT_RELEASE);
        done_s          = (state_s == ST_DONE);
        screen_change_s = screen_change_r || done_s;
    end

    // Registered control outputs.
    always_ff @(posedge sdram_clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_ready_r     <= 1'b0;
            ram_wen_r       <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            screen_change_r <= 1'b0;
        end else begin
            pix_ready_r     <= pix_ready_s;
            ram_wen_r       <= ram_wen_s;
            busy_r          <= busy_s;
            done_r          <= done_s;
            screen_change_r <= screen_change_s;
        end
    end

    // Window latch, cursor walk and pending word; out-of-bounds pixels leave the word untouched.
    always_ff @(posedge sdram_clk or negedge reset_n) begin
        if (!reset_n) begin
            x0_r   <= 14'd0;
            y0_r   <= 14'd0;
            w_r    <= 14'd0;
            h_r    <= 14'd0;
            cx_r   <= 14'd0;
            cy_r   <= 14'd0;
            word_r <= 32'd0;
            mask_r <= 4'd0;
            addr_r <= 32'd0;
            last_r <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && start) begin
                x0_r   <= win_x0;
                y0_r   <= win_y0;
                w_r    <= win_w;
                h_r    <= win_h;
                cx_r   <= win_x0;
                cy_r   <= win_y0;
                word_r <= 32'd0;
                mask_r <= 4'd0;
                last_r <= 1'b0;
            end else if (accept_s) begin
                if (in_bounds_s) begin
                    word_r <= word_s;
                    mask_r <= mask_s;
                    addr_r <= addr_s;
                end else begin
                    word_r <= word_r;
                    mask_r <= mask_r;
                    addr_r <= addr_r;
                end
                last_r <= last_pix_s;
                if (last_col_s) begin
                    cx_r <= x0_r;
                    cy_r <= cy_r + 14'd1;
                end else begin
                    cx_r <= cx_r + 14'd1;
                    cy_r <= cy_r;
                end
            end else if ((state_r == ST_WRITE_REQ) && ram_ack) begin
                word_r <= 32'd0;
                mask_r <= 4'd0;
            end else begin
                word_r <= word_r;
                mask_r <= mask_r;
            end
        end
    end

    assign pix_ready     = pix_ready_r;
    assign ram_wen       = ram_wen_r;
    assign ram_addr      = addr_r;
    assign ram_wdata     = word_r;
    assign ram_wmask     = mask_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign screen_change = screen_change_r;

endmodule
